// File: rtl/ibex_register_file_l1cache.sv
`timescale 1ns/1ps
// Two-level register file: a small fully-associative L1 of recently used
// registers in front of a flop-based L2 that holds every architectural register.
// Misses stall the core while a single FSM writes back, fetches or allocates.
module ibex_register_file_l1cache #(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned L1Entries = 4,
  parameter int unsigned L2Latency = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [4:0]           raddr_a_i,
  input  logic                 rd_a_en_i,
  output logic [DataWidth-1:0] rdata_a_o,
  input  logic [4:0]           raddr_b_i,
  input  logic                 rd_b_en_i,
  output logic [DataWidth-1:0] rdata_b_o,
  input  logic [4:0]           waddr_a_i,
  input  logic [DataWidth-1:0] wdata_a_i,
  input  logic                 we_a_i,
  output logic                 stall_o,
  output logic                 l2_fetch_o
);

  localparam int unsigned ADDR_WIDTH = RV32E ? 4 : 5;
  localparam int unsigned NUM_WORDS  = 2 ** ADDR_WIDTH;
  localparam int unsigned IDX_W      = $clog2(L1Entries);
  localparam int unsigned CNT_W      = 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WB    = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_ALLOC = 3'd4;

  typedef logic [L1Entries-1:0][IDX_W-1:0] rank_t;

  if (L1Entries < 3 || L1Entries > 16) begin : gen_bad_l1entries
    $error("ibex_register_file_l1cache: L1Entries must be within 3..16");
  end
  if (L2Latency < 1 || L2Latency > 4) begin : gen_bad_l2latency
    $error("ibex_register_file_l1cache: L2Latency must be within 1..4");
  end

  // Entry rank: 0 is least recently used, L1Entries-1 is most recently used.
  function automatic rank_t touch(input rank_t r, input logic [IDX_W-1:0] e);
    rank_t o;
    o = r;
    for (int i = 0; i < L1Entries; i++) begin
      if (r[i] > r[e]) o[i] = r[i] - IDX_W'(1);
    end
    o[e] = IDX_W'(L1Entries - 1);
    return o;
  endfunction

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] target_q, target_d;
  logic [IDX_W-1:0]      victim_q, victim_d;
  logic                  is_write_q, is_write_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DataWidth-1:0]  l2_rdata_q, l2_rdata_d;
  logic [L1Entries-1:0]  valid_q, valid_d, dirty_q, dirty_d;
  rank_t                 rank_q, rank_d;
  logic [ADDR_WIDTH-1:0] tag_q  [L1Entries];
  logic [ADDR_WIDTH-1:0] tag_d  [L1Entries];
  logic [DataWidth-1:0]  data_q [L1Entries];
  logic [DataWidth-1:0]  data_d [L1Entries];
  logic [DataWidth-1:0]  l2_q   [NUM_WORDS];
  logic [DataWidth-1:0]  l2_d   [NUM_WORDS];

  logic [ADDR_WIDTH-1:0] addr_a, addr_b, addr_w;
  logic                  nz_a, nz_b, nz_w;
  logic [L1Entries-1:0]  match_a, match_b, match_w, excl;
  logic [IDX_W-1:0]      idx_a, idx_b, idx_w, victim_sel;
  logic                  miss_a, miss_b, miss_w, miss_any;
  logic                  do_fill;
  logic [DataWidth-1:0]  fill_data;
  logic                  unused_addr_msb;

  // In RV32E mode the top address bit is simply not looked at.
  assign addr_a = raddr_a_i[ADDR_WIDTH-1:0];
  assign addr_b = raddr_b_i[ADDR_WIDTH-1:0];
  assign addr_w = waddr_a_i[ADDR_WIDTH-1:0];
  assign unused_addr_msb = raddr_a_i[4] ^ raddr_b_i[4] ^ waddr_a_i[4];
  assign nz_a = (addr_a != '0);
  assign nz_b = (addr_b != '0);
  assign nz_w = (addr_w != '0);

  for (genvar gi = 0; gi < L1Entries; gi++) begin : gen_match
    assign match_a[gi] = valid_q[gi] && (tag_q[gi] == addr_a);
    assign match_b[gi] = valid_q[gi] && (tag_q[gi] == addr_b);
    assign match_w[gi] = valid_q[gi] && (tag_q[gi] == addr_w);
    // Entries the current reads still need must never be chosen as victims.
    assign excl[gi]    = (rd_a_en_i && match_a[gi]) || (rd_b_en_i && match_b[gi]);
  end

  // x0 and disabled ports always hit; writes to x0 never allocate.
  assign miss_a   = rd_a_en_i && nz_a && !(|match_a);
  assign miss_b   = rd_b_en_i && nz_b && !(|match_b);
  assign miss_w   = we_a_i && nz_w && !(|match_w);
  assign miss_any = miss_a || miss_b || miss_w;

  assign stall_o    = !rst_i && ((state_q != S_IDLE) || miss_any);
  assign l2_fetch_o = !rst_i && (state_q == S_FETCH);

  // Encode hit indices and drive read data straight from the matching entry.
  always_comb begin
    idx_a     = '0;
    idx_b     = '0;
    idx_w     = '0;
    rdata_a_o = '0;
    rdata_b_o = '0;
    for (int i = 0; i < L1Entries; i++) begin
      if (match_a[i]) idx_a = IDX_W'(i);
      if (match_b[i]) idx_b = IDX_W'(i);
      if (match_w[i]) idx_w = IDX_W'(i);
      if (match_a[i] && nz_a) rdata_a_o = rdata_a_o | data_q[i];
      if (match_b[i] && nz_b) rdata_b_o = rdata_b_o | data_q[i];
    end
  end

  // Victim: first free unexcluded entry, otherwise the unexcluded entry of lowest rank.
  always_comb begin
    logic             found_free;
    logic             found_lru;
    logic [IDX_W-1:0] best_rank;
    found_free = 1'b0;
    found_lru  = 1'b0;
    best_rank  = '0;
    victim_sel = '0;
    for (int i = 0; i < L1Entries; i++) begin
      if (!found_free && !valid_q[i] && !excl[i]) begin
        victim_sel = IDX_W'(i);
        found_free = 1'b1;
      end
    end
    if (!found_free) begin
      for (int i = 0; i < L1Entries; i++) begin
        if (!excl[i] && (!found_lru || rank_q[i] < best_rank)) begin
          victim_sel = IDX_W'(i);
          best_rank  = rank_q[i];
          found_lru  = 1'b1;
        end
      end
    end
  end

  // Next state: dispatch one miss (A, then B, then W), or commit hits and refresh LRU.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    victim_d   = victim_q;
    is_write_d = is_write_q;
    cnt_d      = cnt_q;
    l2_rdata_d = l2_rdata_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    rank_d     = rank_q;
    tag_d      = tag_q;
    data_d     = data_q;
    l2_d       = l2_q;
    do_fill    = 1'b0;
    fill_data  = '0;
    case (state_q)
      S_IDLE: begin
        if (miss_any) begin
          target_d   = miss_a ? addr_a : (miss_b ? addr_b : addr_w);
          is_write_d = !miss_a && !miss_b;
          victim_d   = victim_sel;
          if (valid_q[victim_sel] && dirty_q[victim_sel]) state_d = S_WB;
          else if (!miss_a && !miss_b)                      state_d = S_ALLOC;
          else                                              state_d = S_FETCH;
        end else begin
          if (rd_a_en_i && nz_a) rank_d = touch(rank_d, idx_a);
          if (rd_b_en_i && nz_b) rank_d = touch(rank_d, idx_b);
          if (we_a_i && nz_w) begin
            data_d[idx_w]  = wdata_a_i;
            dirty_d[idx_w] = 1'b1;
            rank_d         = touch(rank_d, idx_w);
          end
        end
      end
      S_WB: begin
        l2_d[tag_q[victim_q]] = data_q[victim_q];
        dirty_d[victim_q]     = 1'b0;
        state_d               = is_write_q ? S_ALLOC : S_FETCH;
      end
      S_FETCH: begin
        l2_rdata_d = l2_q[target_q];
        cnt_d      = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(L2Latency - 1)) begin
          do_fill   = 1'b1;
          fill_data = l2_rdata_q;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ALLOC: begin
        do_fill = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (do_fill) begin
      valid_d[victim_q] = 1'b1;
      dirty_d[victim_q] = 1'b0;
      tag_d[victim_q]   = target_q;
      data_d[victim_q]  = fill_data;
      rank_d            = touch(rank_d, victim_q);
    end
  end

  // State registers; reset empties L1, zeroes L2 and abandons any miss in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      target_q   <= '0;
      victim_q   <= '0;
      is_write_q <= 1'b0;
      cnt_q      <= '0;
      l2_rdata_q <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      for (int i = 0; i < L1Entries; i++) begin
        rank_q[i] <= IDX_W'(i);
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
      for (int i = 0; i < NUM_WORDS; i++) l2_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      victim_q   <= victim_d;
      is_write_q <= is_write_d;
      cnt_q      <= cnt_d;
      l2_rdata_q <= l2_rdata_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      rank_q     <= rank_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
      l2_q       <= l2_d;
    end
  end

endmodule
